// File: rtl/wb_trace_capture.sv
// wb_trace_capture: commit-trace receiver for the core's writeback debug port.
// Each retired instruction seen while capture_en is high becomes a 70-bit
// normalised record {pc, ena, reg, value}. Records are queued in a
// first-word-fall-through FIFO and offered on a valid/ready stream. Commit and
// drop counters plus a sticky overflow flag make lost records visible.
//
// Optional feature macro: WB_TRACE_SHADOW_EN
//   When defined, a 31x32 shadow register file tracks every normalised write,
//   including writes whose records were dropped. It is read through
//   shadow_addr / shadow_data.
//
// Stream handshake: trace_valid is high whenever the FIFO holds a record, and
// trace_* present the head record. A record transfers on a rising edge where
// trace_valid && trace_ready. While trace_valid=1 and trace_ready=0, every
// trace_* output holds steady. trace_valid never depends on trace_ready.
module wb_trace_capture #(
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             capture_en,
   input  logic             ovf_clr,
   input  logic             debug_wb_have_inst,
   input  logic [31:0]      debug_wb_pc,
   input  logic             debug_wb_ena,
   input  logic [4:0]       debug_wb_reg,
   input  logic [31:0]      debug_wb_value,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [31:0]      trace_pc,
   output logic             trace_ena,
   output logic [4:0]       trace_reg,
   output logic [31:0]      trace_value,
   output logic [LVL_W-1:0] level,
   output logic [31:0]      commit_count,
   output logic [15:0]      drop_count,
`ifdef WB_TRACE_SHADOW_EN
   input  logic [4:0]       shadow_addr,
   output logic [31:0]      shadow_data,
`endif
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int REC_W = 70;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [REC_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic             ev;
   logic             wb_keep;
   logic             push;
   logic             pop;
   logic             drop;
   logic [REC_W-1:0] rec_in;

   // Event qualification, record normalisation and push/pop/drop decisions.
   always_comb begin
      ev      = debug_wb_have_inst && capture_en;
      wb_keep = debug_wb_ena && (debug_wb_reg != 5'd0);
      rec_in  = {debug_wb_pc, wb_keep,
                 wb_keep ? debug_wb_reg : 5'd0,
                 wb_keep ? debug_wb_value : 32'd0};
      pop     = trace_valid && trace_ready;
      // A full FIFO still accepts a record when the head leaves in the same cycle.
      push    = ev && ((level != FULL_LVL) || pop);
      drop    = ev && !push;
   end

   // FIFO storage: cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= rec_in;
      end
   end

   // Pointers and occupancy; full and empty are told apart by level alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Commit counter (wraps), drop counter (saturates) and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_count <= '0;
         drop_count   <= '0;
         overflow     <= 1'b0;
      end else begin
         if (ev) begin
            commit_count <= commit_count + 32'd1;
         end
         // A drop in the same cycle as a clear restarts the count at one.
         if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
               drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end
      end
   end

   // Head record presentation (first-word fall-through).
   always_comb begin
      trace_valid = (level != '0);
      {trace_pc, trace_ena, trace_reg, trace_value} = mem[rd_ptr];
   end

`ifdef WB_TRACE_SHADOW_EN
   logic [31:0] shadow_q [31:1];

   // Shadow register file: follows every normalised write, dropped or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (ev && wb_keep) begin
         shadow_q[debug_wb_reg] <= debug_wb_value;
      end
   end

   // Shadow read port; x0 is hardwired to zero.
   always_comb begin
      shadow_data = 32'd0;
      if (shadow_addr != 5'd0) begin
         shadow_data = shadow_q[shadow_addr];
      end
   end
`endif

endmodule

// File: doc/wb_trace_capture.md
# wb_trace_capture

Commit-trace receiver for the pipelined core's writeback debug port. It samples every retired instruction reported on the debug_wb_* bus and normalises it into a 70-bit record. Records are buffered in a FIFO and presented on a valid/ready stream, for a bench scoreboard, a UART dumper or an on-chip logic analyser. Commit and drop counters and a sticky overflow flag make lost records detectable.

## Interface
- DEPTH, 16: FIFO entries; power of two, 4..256.
- LVL_W, $clog2(DEPTH)+1: width of the level output.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- capture_en  in  1  while high, commits are captured and counted.
- ovf_clr  in  1  single-cycle pulse that clears the overflow flag and drop_count.
- debug_wb_have_inst  in  1  a commit happened this cycle.
- debug_wb_pc  in  32  PC of the committed instruction.
- debug_wb_ena  in  1  register-file write enable of the commit.
- debug_wb_reg  in  5  destination register.
- debug_wb_value  in  32  value written back.
- trace_valid  out  1  a record is present at the FIFO head.
- trace_ready  in  1  consumer accepts the head record.
- trace_pc  out  32  head record PC.
- trace_ena  out  1  head record write enable.
- trace_reg  out  5  head record destination register.
- trace_value  out  32  head record value.
- level  out  LVL_W  FIFO occupancy, 0..DEPTH.
- commit_count  out  32  number of captured commits; wraps.
- drop_count  out  16  number of commits dropped because the FIFO was full; saturates at 16'hFFFF.
- overflow  out  1  sticky; at least one commit has been dropped.
- shadow_addr  in  5  shadow register file read address (only when WB_TRACE_SHADOW_EN is defined).
- shadow_data  out  32  shadow register file read data, combinational (only when WB_TRACE_SHADOW_EN is defined).

## Operation
- Event: an event is debug_wb_have_inst && capture_en sampled at a rising edge. Inputs are ignored when either is low.
- Normalisation:
  - If debug_wb_ena==0 or debug_wb_reg==0, the record stores ena=0, reg=0 and value=0.
  - Otherwise the record stores the inputs unchanged.
  - The PC is always stored unchanged.
- Counting: every event increments commit_count modulo 2^32, whether or not it is stored.
- Push: an event is stored when level<DEPTH, or when level==DEPTH and a pop happens in the same cycle.
- Drop: an event that cannot be stored is discarded. It sets overflow and increments drop_count, saturating at 16'hFFFF.
- Pop: a pop happens when trace_valid && trace_ready. With no pop, the head record and trace_valid hold steady.
- FIFO structure: circular buffer with read and write pointers of log2(DEPTH) bits that wrap at DEPTH. Full and empty are distinguished by level.
- Simultaneous push and pop: level is unchanged.
- ovf_clr: clears overflow and drop_count. If a drop happens in the same cycle, the drop wins: overflow=1 and drop_count=1.
- Reset (rst_n low, asynchronous):
  - pointers=0, level=0, trace_valid=0;
  - commit_count=0, drop_count=0, overflow=0;
  - trace_* data outputs read 0, because the FIFO storage is cleared;
  - when WB_TRACE_SHADOW_EN is defined, all shadow registers are 0.
- Reset mid-stream discards every buffered record. After rst_n deasserts, the first event is captured at the first rising edge.

## Timing
- Write-to-visibility latency: an event sampled at edge N into an empty FIFO gives trace_valid=1 and head data from just after edge N, i.e. 1 cycle.
- Stream: first-word fall-through. Head data changes only after a pop edge.
- Throughput: one event per cycle. Sustained DEPTH-plus-one bursts with no pops drop exactly one event.
- Status outputs: level, the counters and overflow are registered and update at the same edge as the push or pop.
- Stability rule: while trace_valid=1 and trace_ready=0, all trace_* outputs hold stable across cycles.

## Configuration
- WB_TRACE_SHADOW_EN, when defined:
  - Adds a 31x32 shadow register file, updated on every event with normalised ena=1, including dropped events.
  - x0 always reads 0.
  - The shadow file is written at the event edge, so shadow_data reflects the write in the following cycle.
  - This gives a full architectural register snapshot independent of FIFO loss.
- When not defined: the shadow_addr and shadow_data ports and all their storage are absent.

## Test plan
- Reset, then single event: pc=0x0000_0040, ena=1, reg=5, value=0xDEAD_BEEF with trace_ready=0 -> next cycle trace_valid=1, level=1, record matches, commit_count=1; record held for 10 cycles.
- Normalisation: event with ena=1, reg=0, value=0x1234 -> record ena=0, reg=0, value=0. Event with ena=0, reg=7, value=0x55 -> ena=0, reg=0, value=0.
- Overflow: DEPTH=16, trace_ready=0, 18 consecutive events -> level=16, drop_count=2, overflow=1, commit_count=18. Draining yields the first 16 PCs in order.
- Full plus simultaneous pop and push: at level=16 with trace_ready=1 and an event -> level stays 16, no drop. Same cycle with ovf_clr=1 and a drop -> overflow=1, drop_count=1.
- Async reset mid-burst: assert rst_n low between edges while level=9 -> trace_valid=0, level=0 and counters=0 immediately, without waiting for a clock edge.
- Shadow (WB_TRACE_SHADOW_EN defined): write reg=3 value=0xA5A5_0001 during a full-FIFO drop -> shadow_addr=3 reads 0xA5A5_0001 next cycle; shadow_addr=0 reads 0.
